// File: rtl/io_uart_port_if.sv
// Command/response channel between the IO command controller and a UART port.
// Pure wiring, no latency.
// Both directions are ACK (valid) / REQ (ready): a transfer happens when both are high.
interface io_uart_port_if;
    logic        CmdACK;
    logic        CmdREQ;
    logic        CmdResponseRequested;
    logic [3:0]  CmdDestReg;
    logic [15:0] CmdData;
    logic        RespACK;
    logic        RespREQ;
    logic        RespRegResponseFlag;
    logic        RespMemResponseFlag;
    logic [3:0]  RespDestReg;
    logic [15:0] RespData;

    // Controller side
    modport master (
        output CmdACK, CmdResponseRequested, CmdDestReg, CmdData, RespREQ,
        input  CmdREQ, RespACK, RespRegResponseFlag, RespMemResponseFlag, RespDestReg, RespData
    );

    // UART port side
    modport slave (
        input  CmdACK, CmdResponseRequested, CmdDestReg, CmdData, RespREQ,
        output CmdREQ, RespACK, RespRegResponseFlag, RespMemResponseFlag, RespDestReg, RespData
    );
endinterface

// File: rtl/io_uart_port.sv
// One UART channel (8N1 TX, oversampled RX, RX FIFO, status, divisor) behind a command/response bus.
// Latency: command accepted in one cycle; response valid the cycle after acceptance (TX: after the load).
// Backpressure: CmdREQ low while a TX waits for the engine or a response waits for RespREQ.
module io_uart_port #(
    parameter logic [11:0] DEFAULT_DIVISOR = 12'd868,
    parameter int          RXFIFODEPTH     = 4,
    parameter int          SYNCSTAGES      = 2
) (
    input  logic         clk,
    input  logic         async_rst,
    io_uart_port_if.slave bus,
    output logic         uart_tx,
    input  logic         uart_rx
);
    localparam int PW = $clog2(RXFIFODEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] OP_TX = 2'b00, OP_RXREAD = 2'b01, OP_STATUS = 2'b10, OP_DIVISOR = 2'b11;

    typedef enum logic [1:0] {C_IDLE, C_WAIT_TX, C_RESP} cmdState_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rxState_t;

    cmdState_t cmdState, cmdNext;
    rxState_t  rxState, rxNext;
    logic        alive, cmdXfer, txLoad, fifoPop, fifoPush, statusRd, divWr;
    logic [1:0]  op;
    logic [11:0] payload, newDiv, divisor;
    logic [15:0] respNext, respDat, statusWord;
    logic [7:0]  txByte, pendByte;
    logic [3:0]  respDest;
    logic        pendResp;
    logic [9:0]  txShift;
    logic        txBusy;
    logic [11:0] txCnt, txDiv;
    logic [3:0]  txBits;
    logic [SYNCSTAGES-1:0] rxSync;
    logic        rxIn, rxPrev, rxTick, rxPush, rxFrameErr;
    logic [11:0] rxCnt, rxDiv;
    logic [2:0]  rxBit;
    logic [7:0]  rxShift;
    logic [7:0]  rxMem [RXFIFODEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] rxCount;
    logic        rxFull, overrunSet, framingFlag, overrunFlag;
    logic [2:0]  countField;
    logic [31:0] count32;
    logic        unusedCmdBits;

    assign op      = bus.CmdData[15:14];
    assign payload = bus.CmdData[11:0];
    assign newDiv  = (payload < 12'd4) ? 12'd4 : payload;
    assign unusedCmdBits = ^bus.CmdData[13:12];
    assign cmdXfer = bus.CmdACK && alive && (cmdState == C_IDLE);
    assign rxFull  = (rxCount == CW'(RXFIFODEPTH));
    assign uart_tx = txShift[0];
    assign bus.RespACK             = (cmdState == C_RESP);
    assign bus.RespRegResponseFlag = (cmdState == C_RESP);
    assign bus.RespMemResponseFlag = 1'b0;
    assign bus.RespData            = respDat;
    assign bus.RespDestReg         = respDest;

    // Status word with the FIFO count squeezed into a 3-bit field
    always_comb begin
        count32    = 32'(rxCount);
        countField = (count32 > 32'd7) ? 3'd7 : count32[2:0];
        statusWord = {9'b0, countField, framingFlag, overrunFlag, rxFull, txBusy};
    end

    // Command FSM: state register plus a flag that holds CmdREQ low until the first clock after reset
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            cmdState <= C_IDLE;
            alive    <= 1'b0;
        end else begin
            cmdState <= cmdNext;
            alive    <= 1'b1;
        end
    end

    // Command FSM: next state
    always_comb begin
        cmdNext = cmdState;
        case (cmdState)
            C_IDLE: if (cmdXfer) begin
                if (op == OP_TX && txBusy)          cmdNext = C_WAIT_TX;
                else if (bus.CmdResponseRequested)  cmdNext = C_RESP;
            end
            C_WAIT_TX: if (!txBusy) cmdNext = pendResp ? C_RESP : C_IDLE;
            C_RESP:    if (bus.RespREQ) cmdNext = C_IDLE;
            default:   cmdNext = C_IDLE;
        endcase
    end

    // Command FSM: strobes to the datapath and the response word to capture
    always_comb begin
        bus.CmdREQ = 1'b0;
        txLoad     = 1'b0;
        txByte     = bus.CmdData[7:0];
        fifoPop    = 1'b0;
        statusRd   = 1'b0;
        divWr      = 1'b0;
        respNext   = 16'h0000;
        case (cmdState)
            C_IDLE: begin
                bus.CmdREQ = alive;
                if (cmdXfer) begin
                    case (op)
                        OP_TX: begin
                            txLoad   = !txBusy;
                            respNext = 16'h0001;
                        end
                        OP_RXREAD: begin
                            fifoPop  = (rxCount != '0);
                            respNext = fifoPop ? {7'b0, 1'b1, rxMem[rdPtr]} : 16'h0000;
                        end
                        OP_STATUS: begin
                            statusRd = 1'b1;
                            respNext = statusWord;
                        end
                        default: begin
                            divWr    = 1'b1;
                            respNext = {4'b0, newDiv};
                        end
                    endcase
                end
            end
            C_WAIT_TX: begin
                txLoad   = !txBusy;
                txByte   = pendByte;
                respNext = 16'h0001;
            end
            default: ;
        endcase
    end

    // Command datapath: pending TX byte, response payload, divisor, sticky flags
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            respDat     <= 16'h0000;
            respDest    <= 4'h0;
            pendByte    <= 8'h00;
            pendResp    <= 1'b0;
            divisor     <= DEFAULT_DIVISOR;
            framingFlag <= 1'b0;
            overrunFlag <= 1'b0;
        end else begin
            if (cmdXfer) begin
                respDest <= bus.CmdDestReg;
                pendByte <= bus.CmdData[7:0];
                pendResp <= bus.CmdResponseRequested;
            end
            if (cmdState != C_RESP && cmdNext == C_RESP) respDat <= respNext;
            if (divWr) divisor <= newDiv;
            framingFlag <= (framingFlag && !statusRd) || rxFrameErr;
            overrunFlag <= (overrunFlag && !statusRd) || overrunSet;
        end
    end

    // TX engine: shift {stop, data, start} out LSB first, divisor latched at load
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            txShift <= '1;
            txBusy  <= 1'b0;
            txCnt   <= 12'd0;
            txDiv   <= DEFAULT_DIVISOR;
            txBits  <= 4'd0;
        end else if (txLoad) begin
            txShift <= {1'b1, txByte, 1'b0};
            txBusy  <= 1'b1;
            txCnt   <= divisor - 12'd1;
            txDiv   <= divisor;
            txBits  <= 4'd9;
        end else if (txBusy) begin
            if (txCnt == 12'd0) begin
                if (txBits == 4'd0) begin
                    txBusy <= 1'b0;
                end else begin
                    txShift <= {1'b1, txShift[9:1]};
                    txBits  <= txBits - 4'd1;
                    txCnt   <= txDiv - 12'd1;
                end
            end else begin
                txCnt <= txCnt - 12'd1;
            end
        end
    end

    // RX input synchroniser and edge-detect history (line idles high)
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            rxSync <= '1;
            rxPrev <= 1'b1;
        end else begin
            rxSync <= {rxSync[SYNCSTAGES-2:0], uart_rx};
            rxPrev <= rxIn;
        end
    end
    assign rxIn   = rxSync[SYNCSTAGES-1];
    assign rxTick = (rxCnt == 12'd0);

    // RX FSM: state register
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) rxState <= R_IDLE;
        else            rxState <= rxNext;
    end

    // RX FSM: next state (false start returns to idle)
    always_comb begin
        rxNext = rxState;
        case (rxState)
            R_IDLE:  if (rxPrev && !rxIn) rxNext = R_START;
            R_START: if (rxTick) rxNext = rxIn ? R_IDLE : R_DATA;
            R_DATA:  if (rxTick && rxBit == 3'd7) rxNext = R_STOP;
            R_STOP:  if (rxTick) rxNext = R_IDLE;
            default: rxNext = R_IDLE;
        endcase
    end

    // RX FSM: frame-complete strobes on the stop-bit sample
    always_comb begin
        rxPush     = (rxState == R_STOP) && rxTick && rxIn;
        rxFrameErr = (rxState == R_STOP) && rxTick && !rxIn;
    end

    // RX datapath: half-bit then full-bit countdown, divisor frozen once a start edge is seen
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            rxCnt   <= 12'd0;
            rxDiv   <= DEFAULT_DIVISOR;
            rxBit   <= 3'd0;
            rxShift <= 8'h00;
        end else if (rxState == R_IDLE) begin
            rxDiv <= divisor;
            rxCnt <= {1'b0, divisor[11:1]} - 12'd1;
            rxBit <= 3'd0;
        end else if (rxTick) begin
            rxCnt <= rxDiv - 12'd1;
            if (rxState == R_DATA) begin
                rxShift <= {rxIn, rxShift[7:1]};
                rxBit   <= rxBit + 3'd1;
            end
        end else begin
            rxCnt <= rxCnt - 12'd1;
        end
    end

    // A full FIFO still accepts a byte when a read frees a slot in the same cycle
    assign fifoPush   = rxPush && (!rxFull || fifoPop);
    assign overrunSet = rxPush && rxFull && !fifoPop;

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or negedge async_rst) begin
        if (!async_rst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            rxCount <= '0;
        end else begin
            if (fifoPush) wrPtr <= wrPtr + PW'(1);
            if (fifoPop)  rdPtr <= rdPtr + PW'(1);
            case ({fifoPush, fifoPop})
                2'b10:   rxCount <= rxCount + CW'(1);
                2'b01:   rxCount <= rxCount - CW'(1);
                default: ;
            endcase
        end
    end

    // RX FIFO storage
    always_ff @(posedge clk) begin
        if (fifoPush) rxMem[wrPtr] <= rxShift;
    end
endmodule

// File: tb/tb_io_uart_port.sv
// Randomised scoreboard bench for io_uart_port: a queue-based UART/FIFO model predicts responses and TX frames.
module tb_io_uart_port;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic uart_tx;
    logic uart_rx = 1'b1;
    always #5 clk = ~clk;

    io_uart_port_if bus();

    io_uart_port #(.DEFAULT_DIVISOR(12'd8), .RXFIFODEPTH(DEPTH), .SYNCSTAGES(2)) dut (
        .clk(clk), .async_rst(arst_n), .bus(bus), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    typedef struct { logic [3:0] dest; logic [15:0] data; } resp_t;
    typedef struct { logic [7:0] b; bit b2b; } txe_t;

    int checks = 0;
    int errors = 0;
    resp_t respQ[$];
    txe_t  txQ[$];
    logic [7:0] rxModel[$];
    bit framingM = 0, overrunM = 0, nextB2B = 0, decOff = 0;
    int divM = 8;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference behaviour of one accepted command; updates the model state
    function automatic logic [15:0] model_cmd(input logic [1:0] op, input logic [11:0] pl);
        logic [15:0] v;
        case (op)
            2'b00: begin txe_t t; t.b = pl[7:0]; t.b2b = nextB2B; txQ.push_back(t); v = 16'h0001; end
            2'b01: v = (rxModel.size() != 0) ? {8'h01, rxModel.pop_front()} : 16'h0000;
            2'b10: begin
                v = {9'b0, 3'(rxModel.size()), framingM, overrunM, rxModel.size() == DEPTH, 1'b0};
                framingM = 0;
                overrunM = 0;
            end
            default: begin divM = (pl < 12'd4) ? 4 : int'(pl); v = 16'(divM); end
        endcase
        return v;
    endfunction

    task automatic send_cmd(input logic [1:0] op, input logic [11:0] pl, input bit rr,
                            input logic [3:0] dest, input bit chkLat);
        int n;
        resp_t e;
        @(negedge clk);
        bus.CmdACK = 1'b1;
        bus.CmdData = {op, 2'b00, pl};
        bus.CmdResponseRequested = rr;
        bus.CmdDestReg = dest;
        n = 0;
        while (bus.CmdREQ !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        check("cmd_accept", bus.CmdREQ, 1);
        if (bus.CmdREQ === 1'b1) begin
            e.data = model_cmd(op, pl);
            e.dest = dest;
            if (rr) respQ.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.CmdACK = 1'b0;
        if (rr && chkLat) begin
            @(negedge clk);
            check("resp_latency", bus.RespACK, 1);
        end
    endtask

    task automatic drive_rx(input logic [7:0] b, input bit goodStop);
        @(negedge clk) uart_rx = 1'b0;
        repeat (divM) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (divM) @(negedge clk);
        end
        uart_rx = goodStop;
        repeat (divM) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * divM + 4) @(negedge clk);
        if (!goodStop) framingM = 1;
        else if (rxModel.size() == DEPTH) overrunM = 1;
        else rxModel.push_back(b);
    endtask

    task automatic wait_tx_drain();
        int n;
        n = 0;
        while (txQ.size() != 0 && n < 40 * divM + 200) begin @(negedge clk); n++; end
        check("tx_drain_bound", txQ.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Response monitor: picks RespREQ each cycle and scores every transfer it will cause
    initial begin : respMonitor
        resp_t e;
        bus.RespREQ = 1'b0;
        forever begin
            @(negedge clk);
            bus.RespREQ = ($urandom_range(0, 2) != 0);
            if (arst_n && bus.RespACK === 1'b1 && bus.RespREQ) begin
                check("resp_q_nonempty", respQ.size() != 0, 1);
                if (respQ.size() != 0) begin
                    e = respQ.pop_front();
                    check("resp", {bus.RespDestReg, bus.RespData, bus.RespRegResponseFlag, bus.RespMemResponseFlag},
                          {e.dest, e.data, 1'b1, 1'b0});
                end
            end
        end
    end

    // TX line decoder: every bit must hold its value for exactly the divisor period
    initial begin : txDecoder
        int d, idleCnt;
        logic [7:0] b;
        bit ok;
        txe_t e;
        idleCnt = 100;
        forever begin
            @(negedge clk);
            if (!arst_n || uart_tx !== 1'b0) begin
                idleCnt++;
            end else begin
                d = divM;
                ok = 1;
                repeat (d - 1) begin @(negedge clk); if (uart_tx !== 1'b0) ok = 0; end
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    b[i] = uart_tx;
                    repeat (d - 1) begin @(negedge clk); if (uart_tx !== b[i]) ok = 0; end
                end
                repeat (d) begin @(negedge clk); if (uart_tx !== 1'b1) ok = 0; end
                if (!decOff) begin
                    check("txq_nonempty", txQ.size() != 0, 1);
                    if (txQ.size() != 0) begin
                        e = txQ.pop_front();
                        check("tx_frame", {ok, b}, {1'b1, e.b});
                        if (e.b2b) check("tx_b2b_gap", idleCnt <= 1, 1);
                    end
                end
                idleCnt = 0;
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n, r;
        bus.CmdACK = 1'b0;
        bus.CmdData = 16'h0000;
        bus.CmdResponseRequested = 1'b0;
        bus.CmdDestReg = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_cmd_req", bus.CmdREQ, 0);
        check("rst_resp_ack", bus.RespACK, 0);
        check("rst_resp_data", bus.RespData, 0);
        check("rst_resp_dest", bus.RespDestReg, 0);
        arst_n = 1'b1;
        @(negedge clk);
        check("cmd_req_after_rst", bus.CmdREQ, 1);

        send_cmd(2'b10, 12'h000, 1, 4'd5, 1);        // status after reset
        send_cmd(2'b00, 12'h055, 1, 4'd3, 1);        // single TX frame
        wait_tx_drain();

        send_cmd(2'b00, 12'h0A3, 0, 4'd0, 0);        // back-to-back TX pair
        nextB2B = 1;
        send_cmd(2'b00, 12'h03C, 1, 4'd7, 0);
        nextB2B = 0;
        @(negedge clk);
        check("wait_tx_stall", bus.CmdREQ, 0);
        wait_tx_drain();

        drive_rx(8'hA5, 1);
        drive_rx(8'h3C, 1);
        repeat (3) send_cmd(2'b01, 12'h000, 1, 4'd1, 1);

        for (int i = 0; i < 5; i++) drive_rx(8'($urandom), 1);
        send_cmd(2'b10, 12'h000, 1, 4'd2, 1);
        send_cmd(2'b10, 12'h000, 1, 4'd2, 1);
        repeat (5) send_cmd(2'b01, 12'h000, 1, 4'd4, 1);

        drive_rx(8'($urandom), 0);                  // bad stop bit
        send_cmd(2'b10, 12'h000, 1, 4'd6, 1);
        @(negedge clk) uart_rx = 1'b0;              // short low glitch
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        send_cmd(2'b10, 12'h000, 1, 4'd6, 1);
        send_cmd(2'b01, 12'h000, 1, 4'd6, 1);

        send_cmd(2'b11, 12'h002, 1, 4'd8, 1);
        send_cmd(2'b11, 12'h008, 1, 4'd8, 1);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: begin send_cmd(2'b00, 12'($urandom_range(0, 255)), 1'($urandom), 4'($urandom), 0); wait_tx_drain(); end
                1, 2: drive_rx(8'($urandom), $urandom_range(0, 5) != 0);
                3: send_cmd(2'b01, 12'h000, 1'($urandom), 4'($urandom), 0);
                4: send_cmd(2'b10, 12'h000, 1'($urandom), 4'($urandom), 0);
                default: send_cmd(2'b11, 12'($urandom_range(0, 12)), 1'($urandom), 4'($urandom), 0);
            endcase
        end

        n = 0;
        while (respQ.size() != 0 && n < 200) begin @(negedge clk); n++; end
        check("resp_drain", respQ.size(), 0);
        check("tx_drain", txQ.size(), 0);

        decOff = 1;                                  // frame about to be aborted by reset
        send_cmd(2'b00, 12'h000, 0, 4'd0, 0);
        repeat (2 * divM + 2) @(negedge clk);
        check("abort_mid_frame_low", uart_tx, 0);
        arst_n = 1'b0;
        #1;
        check("abort_uart_tx", uart_tx, 1);
        check("abort_cmd_req", bus.CmdREQ, 0);
        check("abort_resp_ack", bus.RespACK, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
